// File: rtl/cnn_pkg.sv
// Shared CNN constants and the window-tap addressing helper.
package cnn_pkg;

   localparam int DATA_W = 12;
   localparam int IMG_W  = 12;
   localparam int K      = 5;
   localparam int CNT_W  = $clog2(IMG_W);

   // Age (in accepted pixels) of window tap (r, c) relative to the newest pixel.
   function automatic int tap_age(input int r, input int c, input int img_w, input int k);
      return (k - 1 - r) * img_w + (k - 1 - c);
   endfunction

endpackage

// File: rtl/conv2_tap_shift.sv
// Enable-gated pixel shift chain exposing a flat KW x KW window of taps.
module conv2_tap_shift
   import cnn_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int STRIDE = 12,
   parameter int KW     = 5,
   parameter int DEPTH  = (KW - 1) * STRIDE + KW
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en_i,
   input  logic [WIDTH-1:0]          din_i,
   output logic [KW*KW*WIDTH-1:0]    taps_o
);

   // Entry 0 (LSBs) holds the newest pixel.
   logic [DEPTH*WIDTH-1:0] chain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else if (en_i) begin
         chain_q <= {chain_q[(DEPTH-1)*WIDTH-1:0], din_i};
      end
   end

   for (genvar r = 0; r < KW; r++) begin : g_row
      for (genvar c = 0; c < KW; c++) begin : g_col
         localparam int AGE = tap_age(r, c, STRIDE, KW);
         assign taps_o[(r*KW+c)*WIDTH +: WIDTH] = chain_q[AGE*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/conv2_window_5ks.sv
// 5x5 sliding-window generator over a raster pixel stream.
// Optional frame_done output enabled by defining CONV2_WIN_FRAME_DONE_EN.
module conv2_window_5ks #(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int IMG_W  = cnn_pkg::IMG_W,
   parameter int K      = cnn_pkg::K
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] out_data_0,
   output logic [DATA_W-1:0] out_data_1,
   output logic [DATA_W-1:0] out_data_2,
   output logic [DATA_W-1:0] out_data_3,
   output logic [DATA_W-1:0] out_data_4,
   output logic [DATA_W-1:0] out_data_5,
   output logic [DATA_W-1:0] out_data_6,
   output logic [DATA_W-1:0] out_data_7,
   output logic [DATA_W-1:0] out_data_8,
   output logic [DATA_W-1:0] out_data_9,
   output logic [DATA_W-1:0] out_data_10,
   output logic [DATA_W-1:0] out_data_11,
   output logic [DATA_W-1:0] out_data_12,
   output logic [DATA_W-1:0] out_data_13,
   output logic [DATA_W-1:0] out_data_14,
   output logic [DATA_W-1:0] out_data_15,
   output logic [DATA_W-1:0] out_data_16,
   output logic [DATA_W-1:0] out_data_17,
   output logic [DATA_W-1:0] out_data_18,
   output logic [DATA_W-1:0] out_data_19,
   output logic [DATA_W-1:0] out_data_20,
   output logic [DATA_W-1:0] out_data_21,
   output logic [DATA_W-1:0] out_data_22,
   output logic [DATA_W-1:0] out_data_23,
   output logic [DATA_W-1:0] out_data_24,
`ifdef CONV2_WIN_FRAME_DONE_EN
   output logic              frame_done,
`endif
   output logic              valid_out
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   logic [CW-1:0]          col_q, col_d, row_q, row_d;
   logic                   valid_q, valid_d;
   logic                   last_col, last_row, win_ok;
   logic [K*K*DATA_W-1:0]  taps;

   always_comb begin
      last_col = (col_q == CW'(IMG_W - 1));
      last_row = (row_q == CW'(IMG_W - 1));
      win_ok   = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));
      col_d    = col_q;
      row_d    = row_q;
      valid_d  = valid_in && win_ok;
      if (valid_in) begin
         col_d = last_col ? '0 : col_q + 1'b1;
         if (last_col) begin
            row_d = last_row ? '0 : row_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
      end
   end

   assign valid_out = valid_q;

`ifdef CONV2_WIN_FRAME_DONE_EN
   logic frame_done_q, frame_done_d;

   // The last pixel of a frame always closes its final window.
   assign frame_done_d = valid_in && last_col && last_row;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) frame_done_q <= 1'b0;
      else      frame_done_q <= frame_done_d;
   end

   assign frame_done = frame_done_q;
`endif

   conv2_tap_shift #(
      .WIDTH  (DATA_W),
      .STRIDE (IMG_W),
      .KW     (K)
   ) u_shift (
      .clk    (clk),
      .rst_n  (rst),
      .en_i   (valid_in),
      .din_i  (data_in),
      .taps_o (taps)
   );

   assign out_data_0  = taps[ 0*DATA_W +: DATA_W];
   assign out_data_1  = taps[ 1*DATA_W +: DATA_W];
   assign out_data_2  = taps[ 2*DATA_W +: DATA_W];
   assign out_data_3  = taps[ 3*DATA_W +: DATA_W];
   assign out_data_4  = taps[ 4*DATA_W +: DATA_W];
   assign out_data_5  = taps[ 5*DATA_W +: DATA_W];
   assign out_data_6  = taps[ 6*DATA_W +: DATA_W];
   assign out_data_7  = taps[ 7*DATA_W +: DATA_W];
   assign out_data_8  = taps[ 8*DATA_W +: DATA_W];
   assign out_data_9  = taps[ 9*DATA_W +: DATA_W];
   assign out_data_10 = taps[10*DATA_W +: DATA_W];
   assign out_data_11 = taps[11*DATA_W +: DATA_W];
   assign out_data_12 = taps[12*DATA_W +: DATA_W];
   assign out_data_13 = taps[13*DATA_W +: DATA_W];
   assign out_data_14 = taps[14*DATA_W +: DATA_W];
   assign out_data_15 = taps[15*DATA_W +: DATA_W];
   assign out_data_16 = taps[16*DATA_W +: DATA_W];
   assign out_data_17 = taps[17*DATA_W +: DATA_W];
   assign out_data_18 = taps[18*DATA_W +: DATA_W];
   assign out_data_19 = taps[19*DATA_W +: DATA_W];
   assign out_data_20 = taps[20*DATA_W +: DATA_W];
   assign out_data_21 = taps[21*DATA_W +: DATA_W];
   assign out_data_22 = taps[22*DATA_W +: DATA_W];
   assign out_data_23 = taps[23*DATA_W +: DATA_W];
   assign out_data_24 = taps[24*DATA_W +: DATA_W];

endmodule

// File: tb/tb_conv2_window_5ks.sv
// Directed self-checking bench for conv2_window_5ks (ramp frames, gaps, reset, back-to-back).
module tb_conv2_window_5ks;

   localparam int DW = 12;
   localparam int IW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_in = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          valid_out;
   logic [DW-1:0] od [25];
`ifdef CONV2_WIN_FRAME_DONE_EN
   logic          frame_done;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_win   = 0;

   always #5 clk = ~clk;

   conv2_window_5ks dut (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in),
      .data_in     (data_in),
      .out_data_0  (od[0]),
      .out_data_1  (od[1]),
      .out_data_2  (od[2]),
      .out_data_3  (od[3]),
      .out_data_4  (od[4]),
      .out_data_5  (od[5]),
      .out_data_6  (od[6]),
      .out_data_7  (od[7]),
      .out_data_8  (od[8]),
      .out_data_9  (od[9]),
      .out_data_10 (od[10]),
      .out_data_11 (od[11]),
      .out_data_12 (od[12]),
      .out_data_13 (od[13]),
      .out_data_14 (od[14]),
      .out_data_15 (od[15]),
      .out_data_16 (od[16]),
      .out_data_17 (od[17]),
      .out_data_18 (od[18]),
      .out_data_19 (od[19]),
      .out_data_20 (od[20]),
      .out_data_21 (od[21]),
      .out_data_22 (od[22]),
      .out_data_23 (od[23]),
      .out_data_24 (od[24]),
`ifdef CONV2_WIN_FRAME_DONE_EN
      .frame_done  (frame_done),
`endif
      .valid_out   (valid_out)
   );

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Accept pixel p of a frame whose pixel values are base + p; optionally follow with an idle cycle.
   task automatic push(input int base, input int p, input bit idle);
      int  row, col;
      bit  win;
      row = p / IW;
      col = p % IW;
      win = (row >= 4) && (col >= 4);
      valid_in = 1'b1;
      data_in  = DW'(base + p);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      if (win) n_win++;
      check_eq("valid", valid_out, win);
      if (win) begin
         check_eq("tap0",  od[0],  base + (row - 4) * IW + (col - 4));
         check_eq("tap12", od[12], base + (row - 2) * IW + (col - 2));
         check_eq("tap24", od[24], base + p);
         if (row == 4 && col == 4) begin
            for (int r = 0; r < 5; r++)
               for (int c = 0; c < 5; c++)
                  check_eq($sformatf("first_win_tap%0d", 5*r + c), od[5*r + c],
                           base + (row - 4 + r) * IW + (col - 4 + c));
         end
      end
`ifdef CONV2_WIN_FRAME_DONE_EN
      check_eq("frame_done", frame_done, win && (n_win % 64 == 0));
`endif
      if (idle) begin
         @(posedge clk);
         #1;
         check_eq("idle_valid", valid_out, 0);
         check_eq("idle_hold_tap24", od[24], base + p);
`ifdef CONV2_WIN_FRAME_DONE_EN
         check_eq("idle_frame_done", frame_done, 0);
`endif
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, valid_out, 0);
      check_eq({tag, "_tap0"},  od[0],  0);
      check_eq({tag, "_tap12"}, od[12], 0);
      check_eq({tag, "_tap24"}, od[24], 0);
   endtask

   initial begin
      int s;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b1;
      n_win = 0;

      s = n_win;
      for (int p = 0; p < 144; p++) push(0, p, 1'b0);
      check_eq("ramp_windows", n_win - s, 64);

      s = n_win;
      for (int p = 0; p < 144; p++) push(0, p, 1'b1);
      check_eq("toggle_windows", n_win - s, 64);

      for (int p = 0; p <= 60; p++) push(0, p, 1'b0);
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      rst = 1'b1;
      n_win = 0;

      s = n_win;
      for (int p = 0; p < 144; p++) push(0, p, 1'b0);
      check_eq("post_rst_windows", n_win - s, 64);

      s = n_win;
      for (int p = 0; p < 144; p++) push(0, p, 1'b0);
      for (int p = 0; p < 144; p++) push(1000, p, 1'b0);
      check_eq("b2b_windows", n_win - s, 128);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
